// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
//   Shared constants for the Y86-64 memory stage:
//     - ICODE values (IHALT .. IPOPQ)
//     - stage status codes (SAOK/SHLT/SADR/SINS)
//     - memory-stage FSM state encoding
//     - f_stage_stat: status priority resolution for a newly started instruction
// -----------------------------------------------------------------------------
package mem_access_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Stage status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Fetch address errors outrank illegal instructions, which outrank a bad
  // data address. HALT only reports SHLT when nothing else went wrong.
  function automatic logic [2:0] f_stage_stat(
    input logic       imem_err,
    input logic       instr_valid,
    input logic       has_access,
    input logic       addr_ok,
    input logic [3:0] icode
  );
    if (imem_err)                  return SADR;
    if (!instr_valid)              return SINS;
    if (has_access && !addr_ok)    return SADR;
    if (icode == IHALT)            return SHLT;
    return SAOK;
  endfunction

endpackage

// File: rtl/mem_access_addr_chk.sv
// -----------------------------------------------------------------------------
// mem_addr_chk
//   Combinational access-type decode and data-memory range check. Shared with
//   the pipelined memory stage.
//   Ports:
//     icode_i    instruction code
//     valE_i     ALU result (address for RMMOVQ/MRMOVQ/PUSHQ/CALL)
//     valA_i     register A (write data, or address for POPQ/RET)
//     valP_i     next PC (write data for CALL)
//     is_rd_o    instruction reads data memory
//     is_wr_o    instruction writes data memory
//     addr_o     selected byte address
//     wdata_o    selected write data
//     addr_ok_o  addr+8 fits inside MEM_SIZE (no wrap)
// -----------------------------------------------------------------------------
module mem_addr_chk
  import mem_access_pkg::*;
#(
  parameter int          ADDR_W   = 64,
  parameter logic [63:0] MEM_SIZE = 64'h2000
) (
  input  logic [3:0]        icode_i,
  input  logic [63:0]       valE_i,
  input  logic [63:0]       valA_i,
  input  logic [63:0]       valP_i,
  output logic              is_rd_o,
  output logic              is_wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [63:0]       wdata_o,
  output logic              addr_ok_o
);

  logic [ADDR_W:0] w_end;

  always_comb begin
    is_rd_o = 1'b0;
    is_wr_o = 1'b0;
    addr_o  = valE_i[ADDR_W-1:0];
    wdata_o = valA_i;
    case (icode_i)
      IRMMOVQ, IPUSHQ: is_wr_o = 1'b1;
      ICALL: begin
        is_wr_o = 1'b1;
        wdata_o = valP_i;
      end
      IMRMOVQ:         is_rd_o = 1'b1;
      IPOPQ, IRET: begin
        is_rd_o = 1'b1;
        addr_o  = valA_i[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  // One extra bit keeps the carry, so addresses near the top of the space
  // that would wrap in a plain ADDR_W add are rejected as well.
  assign w_end     = {1'b0, addr_o} + (ADDR_W+1)'(8);
  assign addr_ok_o = (w_end <= (ADDR_W+1)'(MEM_SIZE));

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//   Memory stage of the Y86-64 SEQ core. Decodes the access for the current
//   instruction, runs a req/ack transaction to data memory, returns valM and
//   the stage status, and stalls the core (busy_o) while the access is open.
//   Optional feature macro: MEM_TIMEOUT_EN -- ack watchdog that abandons a
//   request after TIMEOUT_CYC REQ cycles and reports SADR.
//   Ports:
//     clk_i, rst_n_i           clock, asynchronous active-low reset
//     start_i                  one-cycle start pulse for the instruction
//     icode_i, valE_i, valA_i, valP_i, imem_err_i, instr_valid_i
//                              instruction context from fetch/decode/execute
//     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
//                              data-memory request, held until mem_ack_i
//     mem_ack_i, mem_rdata_i   data-memory completion and read data
//     valM_o, stat_o           read result and stage status (held to next start)
//     busy_o                   transaction outstanding
//     done_o                   one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
#(
  parameter int          ADDR_W      = 64,
  parameter logic [63:0] MEM_SIZE    = 64'h2000,
  parameter int          TIMEOUT_CYC = 256
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [3:0]        icode_i,
  input  logic [63:0]       valE_i,
  input  logic [63:0]       valA_i,
  input  logic [63:0]       valP_i,
  input  logic              imem_err_i,
  input  logic              instr_valid_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [63:0]       mem_rdata_i,
  output logic [63:0]       valM_o,
  output logic [2:0]        stat_o,
  output logic              busy_o,
  output logic              done_o
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_access: TIMEOUT_CYC must be at least 1");
  end

  mem_state_e r_state;
  mem_state_e w_next;

  logic              w_is_rd;
  logic              w_is_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [63:0]       w_wdata;
  logic              w_addr_ok;
  logic              w_access;
  logic              w_go_req;
  logic [2:0]        w_stat;
  logic              w_tmo;

  logic              r_we;
  logic              r_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_valm;
  logic [2:0]        r_stat;

  mem_addr_chk #(
    .ADDR_W   (ADDR_W),
    .MEM_SIZE (MEM_SIZE)
  ) u_chk (
    .icode_i   (icode_i),
    .valE_i    (valE_i),
    .valA_i    (valA_i),
    .valP_i    (valP_i),
    .is_rd_o   (w_is_rd),
    .is_wr_o   (w_is_wr),
    .addr_o    (w_addr),
    .wdata_o   (w_wdata),
    .addr_ok_o (w_addr_ok)
  );

  assign w_access = w_is_rd | w_is_wr;
  assign w_stat   = f_stage_stat(imem_err_i, instr_valid_i, w_access,
                                 w_addr_ok, icode_i);
  // Only a clean, in-range access ever reaches the memory port.
  assign w_go_req = w_access & w_addr_ok & ~imem_err_i & instr_valid_i;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter holds the number of REQ cycles already elapsed, so the last
  // allowed cycle is the one where it reads TIMEOUT_CYC-1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE && start_i && w_go_req) begin
      r_cnt <= '0;
    end else if (r_state == ST_REQ) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_tmo = (r_state == ST_REQ) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_next = w_go_req ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        // An ack coinciding with the timeout still completes normally.
        if (mem_ack_i || w_tmo) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (r_state)
      ST_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = r_we;
        busy_o    = 1'b1;
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // ---- transaction / result registers ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_we    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_valm  <= '0;
      r_stat  <= SAOK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_stat <= w_stat;
            if (w_go_req) begin
              r_we    <= w_is_wr;
              r_rd    <= w_is_rd;
              r_addr  <= w_addr;
              r_wdata <= w_wdata;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack_i) begin
            if (r_rd) begin
              r_valm <= mem_rdata_i;
            end
          end else if (w_tmo) begin
            r_stat <= SADR;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign valM_o      = r_valm;
  assign stat_o      = r_stat;

`ifndef SYNTHESIS
  // The core must not issue a new instruction while this stage is occupied.
  a_no_start_when_busy: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) start_i |-> (r_state == ST_IDLE)
  ) else $error("mem_access: start_i while stage busy");
`endif

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [63:0] MSZ = 64'h2000;
  localparam int          TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        imem_err, ivalid;
  logic        req, we;
  logic [63:0] addr, wdata;
  logic        ack;
  logic [63:0] rdata;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  // Behavioural state of the stage as seen from outside
  logic [63:0] m_valm;
  logic [2:0]  m_stat;

  always #5 clk = ~clk;

  mem_access #(
    .ADDR_W      (64),
    .MEM_SIZE    (MSZ),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .icode_i       (icode),
    .valE_i        (valE),
    .valA_i        (valA),
    .valP_i        (valP),
    .imem_err_i    (imem_err),
    .instr_valid_i (ivalid),
    .mem_req_o     (req),
    .mem_we_o      (we),
    .mem_addr_o    (addr),
    .mem_wdata_o   (wdata),
    .mem_ack_i     (ack),
    .mem_rdata_i   (rdata),
    .valM_o        (valM),
    .stat_o        (stat),
    .busy_o        (busy),
    .done_o        (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One instruction through the stage. nreq = REQ cycle in which ack arrives.
  task automatic do_txn(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                        input logic [63:0] vp, input logic ie, input logic iv,
                        input int nreq, input logic [63:0] rd);
    logic        rdx, wrx, acc, ok, goes_req, tmo;
    logic [63:0] ea, ed;
    logic [2:0]  es;
    int          ncyc;
    // expected behaviour from the instruction semantics
    rdx = (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
    wrx = (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
    acc = rdx || wrx;
    ea  = ((ic == IPOPQ) || (ic == IRET)) ? va : ve;
    ed  = (ic == ICALL) ? vp : va;
    ok  = (ea <= MSZ - 64'd8);
    if (ie)              es = SADR;
    else if (!iv)        es = SINS;
    else if (acc && !ok) es = SADR;
    else if (ic == IHALT) es = SHLT;
    else                 es = SAOK;
    goes_req = !ie && iv && acc && ok;
`ifdef MEM_TIMEOUT_EN
    tmo = goes_req && (nreq > TMO);
`else
    tmo = 1'b0;
`endif
    ncyc = tmo ? TMO : nreq;

    @(posedge clk); #1;
    start = 1'b1; icode = ic; valE = ve; valA = va; valP = vp;
    imem_err = ie; ivalid = iv;
    ack = 1'($urandom_range(0, 1));  // ignored while idle
    rdata = {$urandom, $urandom};
    @(negedge clk);
    chk("idle_req", {63'd0, req}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    // context changes after start must not matter
    icode = 4'($urandom); valE = {$urandom, $urandom}; valA = {$urandom, $urandom};
    valP = {$urandom, $urandom}; imem_err = 1'($urandom); ivalid = 1'($urandom);

    if (goes_req) begin
      for (int c = 1; c <= ncyc; c++) begin
        if (c > 1) begin @(posedge clk); #1; end
        ack   = !tmo && (c == nreq);
        rdata = ack ? rd : {$urandom, $urandom};
        @(negedge clk);
        chk("req", {63'd0, req}, 64'd1);
        chk("busy", {63'd0, busy}, 64'd1);
        chk("done_early", {63'd0, done}, 64'd0);
        chk("we", {63'd0, we}, {63'd0, wrx});
        chk("addr", addr, ea);
        if (wrx) chk("wdata", wdata, ed);
      end
      @(posedge clk); #1;
      ack = 1'($urandom_range(0, 1));  // ignored in DONE
      rdata = {$urandom, $urandom};
      if (rdx && !tmo) m_valm = rd;
      m_stat = tmo ? SADR : es;
    end else begin
      ack = 1'($urandom_range(0, 1));
      m_stat = es;
    end
    @(negedge clk);
    chk("done", {63'd0, done}, 64'd1);
    chk("done_req", {63'd0, req}, 64'd0);
    chk("done_busy", {63'd0, busy}, 64'd0);
    chk("stat", {61'd0, stat}, {61'd0, m_stat});
    chk("valM", valM, m_valm);
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("after_busy", {63'd0, busy}, 64'd0);
    chk("hold_stat", {61'd0, stat}, {61'd0, m_stat});
    chk("hold_valM", valM, m_valm);
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    start = 1'b1; icode = IRET; valA = 64'h80; valE = 64'h5000; valP = 64'h0;
    imem_err = 1'b0; ivalid = 1'b1; ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_req", {63'd0, req}, 64'd1);
    chk("rst_pre_addr", addr, 64'h80);
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    m_valm = 64'd0;
    m_stat = SAOK;
    chk("rst_req", {63'd0, req}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_addr", addr, 64'd0);
    chk("rst_stat", {61'd0, stat}, {61'd0, m_stat});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ack = 1'b1; rdata = 64'hBAD0BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("late_ack_done", {63'd0, done}, 64'd0);
      chk("late_ack_req", {63'd0, req}, 64'd0);
      chk("late_ack_valM", valM, m_valm);
      @(posedge clk); #1;
    end
    ack = 1'b0;
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 6))
      0, 1, 2: return 64'($urandom_range(0, 32'h1FF8));
      3:       return MSZ - 64'd8;
      4:       return MSZ - 64'd8 + 64'($urandom_range(1, 16));
      5:       return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    imem_err = 1'b0; ivalid = 1'b1; ack = 1'b0; rdata = '0;
    m_valm = 64'd0; m_stat = SAOK;
    #12;
    chk("reset_req", {63'd0, req}, 64'd0);
    chk("reset_we", {63'd0, we}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_addr", addr, 64'd0);
    chk("reset_wdata", wdata, 64'd0);
    chk("reset_valM", valM, 64'd0);
    chk("reset_stat", {61'd0, stat}, {61'd0, SAOK});
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    do_txn(IRMMOVQ, 64'h100, 64'hDEAD, 64'h0, 1'b0, 1'b1, 3, 64'h0);
    do_txn(IMRMOVQ, 64'h40, 64'h0, 64'h0, 1'b0, 1'b1, 1, 64'h1234);
    do_txn(IPUSHQ, MSZ - 64'd4, 64'h77, 64'h0, 1'b0, 1'b1, 1, 64'h0);
    do_txn(IHALT, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1, 64'h0);
    do_txn(IHALT, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1, 64'h0);
    do_txn(IOPQ, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1, 64'h0);
    do_txn(ICALL, MSZ - 64'd8, 64'h11, 64'h4242, 1'b0, 1'b1, 2, 64'h0);
    do_txn(IPOPQ, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 1'b1, 1, 64'h9);
    do_txn(IPOPQ, 64'h0, 64'h18, 64'h0, 1'b0, 1'b1, 2, 64'hCAFE_F00D_0000_0001);
    do_txn(IRET, 64'h0, MSZ - 64'd7, 64'h0, 1'b0, 1'b1, 1, 64'h0);
    reset_mid();
`ifdef MEM_TIMEOUT_EN
    do_txn(IMRMOVQ, 64'h200, 64'h0, 64'h0, 1'b0, 1'b1, TMO + 1, 64'h55);
    do_txn(IMRMOVQ, 64'h208, 64'h0, 64'h0, 1'b0, 1'b1, TMO, 64'h66);
`endif

    // randomized cases
    for (int n = 0; n < 60; n++) begin
      logic [3:0] ic;
      ic = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 9) == 0) ic = 4'($urandom_range(12, 15));
      do_txn(ic, pick_addr(), pick_addr(), {$urandom, $urandom},
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
             int'($urandom_range(1, 6)), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
